reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//   Parametrised register file: DEPTH x DATA_W storage, one write port, two independently
//   handshaked read ports (A, B) and a per-entry pending scoreboard.
//   Registered reads (1-cycle latency) with write-to-read bypass. Outputs never tristate.
//   Sits between datapath producers (ALU/load unit) and consumers; replaces the fixed
//   4x16 input register bank and its decoded enable/select codes.
// PARAMETERS
//   DATA_W   16                  data width in bits
//   DEPTH    4                   number of entries, >=2, need not be a power of 2
//   ADDR_W   $clog2(DEPTH)       address width; derived, do not override
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   reset       in   1       synchronous, active-high reset
//   clr         in   1       synchronous clear-all: data, valid and pending bits
//   wr_en       in   1       write strobe
//   wr_addr     in   ADDR_W  write address
//   wr_data     in   DATA_W  write data
//   rsv_en      in   1       reserve strobe: mark entry pending (value in flight)
//   rsv_addr    in   ADDR_W  reserve address
//   rd_req_a    in   1       port A read request; held by requester until granted
//   rd_addr_a   in   ADDR_W  port A address
//   rd_gnt_a    out  1       port A grant (combinational)
//   rd_valid_a  out  1       port A data valid, 1 cycle after grant
//   rd_data_a   out  DATA_W  port A data; 0 when rd_valid_a=0
//   rd_hit_a    out  1       entry was written since last reset/clr (qualifies rd_data_a)
//   rd_*_b      -    -       port B, identical to port A
//   err         out  1       sticky: any access to addr >= DEPTH; cleared only by reset/clr
// BEHAVIOUR
//   Reset: all data=0, valid=0, pending=0; rd_valid_*=0, rd_data_*=0, rd_hit_*=0, err=0.
//   Reset overrides every other input. Reset asserted mid-transfer drops the in-flight read.
//   Write: wr_en=1 -> mem[wr_addr]<=wr_data, valid<=1, pending<=0 at the next edge.
//   Reserve: rsv_en=1 -> pending[rsv_addr]<=1. Data and valid bits are unchanged.
//   Same-cycle wr and rsv to the same address: the data is written and pending ends at 1.
//     Reserve wins on pending because it marks a newer producer.
//   Clear: clr=1 -> all data=0, valid=0, pending=0, err=0. Beats wr and rsv in the same cycle.
//     Reads granted in the clr cycle return 0 with hit=0.
//   Grant: rd_gnt_x = rd_req_x & (~pending[addr] | (wr_en & wr_addr==addr)) & ~reset.
//     Pending entry with no matching write -> gnt=0. Requester holds req and addr; no timeout.
//   Read data: on a granted cycle, the next cycle has rd_valid_x=1 and rd_data_x=mem[addr].
//     If wr_en targets the same addr in the grant cycle, wr_data is returned (bypass).
//   Cycles with no grant: rd_valid_x=0 and rd_data_x=0.
//   Ports A and B are independent. Same address on both ports in one cycle: both are granted
//     and both return identical data.
//   Back-to-back reads: a new grant is possible every cycle; throughput is 1 read/port/cycle.
//   Out of range (addr >= DEPTH, only when DEPTH is not a power of 2):
//     - a write or reserve is ignored;
//     - a read is granted and returns data=0, hit=0;
//     - any of these sets err.
//   Arithmetic: none. Compares are ADDR_W wide; no wrap-around of addresses.
// STRUCTURE
//   Package rf_pkg: port-index constants (RD_A=0, RD_B=1) and a helper function for the
//     in-range check (addr < DEPTH).
//   Sub-module rf_read_port: one instance per read port. It contains the grant logic,
//     the bypass mux and the output register.
//   The top level holds storage, valid, pending, err and the write/reserve/clear logic.
// TESTING
//   1 Reset, then read A addr 2 -> gnt=1; next cycle valid=1, data=0x0000, hit=0; err=0.
//   2 Write 0xBEEF@1; next cycle read A@1 and B@1 -> both valid, data=0xBEEF, hit=1.
//   3 rsv@3; hold read A@3 for 3 cycles -> gnt=0, valid=0. Then wr 0x1234@3 with req held
//     -> gnt=1 that cycle; next cycle data=0x1234 (bypass); pending@3 clear.
//   4 Same cycle: wr 0xAAAA@0 and rsv@0 -> data stored; a read A@0 next cycle gets gnt=0.
//     A following wr 0x5555@0 releases it and returns 0x5555.
//   5 clr together with wr 0x7777@2 -> next cycle read@2 returns 0, hit=0. Pending bits clear.
//   6 DEPTH=5 build: wr@6 is ignored and err=1. Read A@6 -> gnt=1, data=0, hit=0.
//     err stays 1 until reset. Assert reset during a granted read -> valid=0 next cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the reg_file_sb register file.
package rf_pkg;

    // Read port indices and count
    localparam int RD_A   = 0;
    localparam int RD_B   = 1;
    localparam int NUM_RD = 2;

    // True when an address names a real entry (matters only for non power-of-2 depths)
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One handshaked read port: grant, write-to-read bypass and registered output.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              pend_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_valid_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              gnt_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              hit_o
);

    logic              wr_match;
    logic              in_range;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              hit_q, hit_d;

    assign wr_match = wr_en_i && (wr_addr_i == addr_i);
    assign in_range = addr_in_range(32'(addr_i), DEPTH);
    assign gnt_o    = req_i && (!pend_i || wr_match) && !reset;

    // Next read result: bypass a same-cycle write, blank on clear or out-of-range address
    always_comb begin
        valid_d = gnt_o;
        data_d  = '0;
        hit_d   = 1'b0;
        if (gnt_o && !clr_i && in_range) begin
            if (wr_match) begin
                data_d = wr_data_i;
                hit_d  = 1'b1;
            end else begin
                data_d = mem_data_i;
                hit_d  = mem_valid_i;
            end
        end
    end

    // Output register; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            hit_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            hit_q   <= hit_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign hit_o   = hit_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-entry pending scoreboard and two independent read ports.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic              rd_gnt_a,
    output logic              rd_valid_a,
    output logic [DATA_W-1:0] rd_data_a,
    output logic              rd_hit_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_gnt_b,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              rd_hit_b,
    output logic              err
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  pend_q;
    logic              err_q, err_d;

    logic              wr_ok, rsv_ok;
    logic              rd_req   [NUM_RD];
    logic [ADDR_W-1:0] rd_addr  [NUM_RD];
    logic              rd_ok    [NUM_RD];
    logic              rd_pend  [NUM_RD];
    logic [DATA_W-1:0] rd_mdata [NUM_RD];
    logic              rd_mval  [NUM_RD];
    logic              rd_gnt   [NUM_RD];
    logic              rd_valid [NUM_RD];
    logic [DATA_W-1:0] rd_data  [NUM_RD];
    logic              rd_hit   [NUM_RD];

    assign wr_ok  = addr_in_range(32'(wr_addr), DEPTH);
    assign rsv_ok = addr_in_range(32'(rsv_addr), DEPTH);

    assign rd_req[RD_A]  = rd_req_a;
    assign rd_addr[RD_A] = rd_addr_a;
    assign rd_req[RD_B]  = rd_req_b;
    assign rd_addr[RD_B] = rd_addr_b;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        assign rd_ok[p]    = addr_in_range(32'(rd_addr[p]), DEPTH);
        assign rd_pend[p]  = rd_ok[p] ? pend_q[rd_addr[p]]  : 1'b0;
        assign rd_mdata[p] = rd_ok[p] ? mem_q[rd_addr[p]]   : '0;
        assign rd_mval[p]  = rd_ok[p] ? valid_q[rd_addr[p]] : 1'b0;

        rf_read_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_port (
            .clk         (clk),
            .reset       (reset),
            .clr_i       (clr),
            .req_i       (rd_req[p]),
            .addr_i      (rd_addr[p]),
            .pend_i      (rd_pend[p]),
            .mem_data_i  (rd_mdata[p]),
            .mem_valid_i (rd_mval[p]),
            .wr_en_i     (wr_en),
            .wr_addr_i   (wr_addr),
            .wr_data_i   (wr_data),
            .gnt_o       (rd_gnt[p]),
            .valid_o     (rd_valid[p]),
            .data_o      (rd_data[p]),
            .hit_o       (rd_hit[p])
        );
    end

    assign rd_gnt_a   = rd_gnt[RD_A];
    assign rd_valid_a = rd_valid[RD_A];
    assign rd_data_a  = rd_data[RD_A];
    assign rd_hit_a   = rd_hit[RD_A];
    assign rd_gnt_b   = rd_gnt[RD_B];
    assign rd_valid_b = rd_valid[RD_B];
    assign rd_data_b  = rd_data[RD_B];
    assign rd_hit_b   = rd_hit[RD_B];

    // Sticky error: any write, reserve or granted read aimed past the last entry
    always_comb begin
        err_d = err_q;
        if ((wr_en && !wr_ok) || (rsv_en && !rsv_ok) ||
            (rd_gnt[RD_A] && !rd_ok[RD_A]) || (rd_gnt[RD_B] && !rd_ok[RD_B])) begin
            err_d = 1'b1;
        end
    end

    // Storage and scoreboard; reserve is applied after write so it wins on pending
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_en && wr_ok) begin
                mem_q[wr_addr]   <= wr_data;
                valid_q[wr_addr] <= 1'b1;
                pend_q[wr_addr]  <= 1'b0;
            end
            if (rsv_en && rsv_ok) begin
                pend_q[rsv_addr] <= 1'b1;
            end
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (DEPTH=5 so out-of-range addresses exist).
module tb_reg_file_sb;

    localparam int DW       = 16;
    localparam int TB_DEPTH = 5;
    localparam int AW       = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, clr, wr_en, rsv_en;
    logic [AW-1:0] wr_addr, rsv_addr;
    logic [DW-1:0] wr_data;
    logic          req    [2];
    logic [AW-1:0] raddr  [2];
    logic          gnt    [2];
    logic          rvalid [2];
    logic [DW-1:0] rdata  [2];
    logic          rhit   [2];
    logic          err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [DW-1:0] m_mem  [TB_DEPTH];
    bit            m_val  [TB_DEPTH];
    bit            m_pend [TB_DEPTH];
    bit            m_err;
    bit            e_valid [2];
    logic [DW-1:0] e_data  [2];
    bit            e_hit   [2];

    reg_file_sb #(.DATA_W(DW), .DEPTH(TB_DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rd_req_a   (req[0]),
        .rd_addr_a  (raddr[0]),
        .rd_gnt_a   (gnt[0]),
        .rd_valid_a (rvalid[0]),
        .rd_data_a  (rdata[0]),
        .rd_hit_a   (rhit[0]),
        .rd_req_b   (req[1]),
        .rd_addr_b  (raddr[1]),
        .rd_gnt_b   (gnt[1]),
        .rd_valid_b (rvalid[1]),
        .rd_data_b  (rdata[1]),
        .rd_hit_b   (rhit[1]),
        .err        (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_rng(input logic [AW-1:0] a);
        return 32'(a) < 32'(TB_DEPTH);
    endfunction

    function automatic bit m_gnt(input int p);
        bit blocked;
        blocked = in_rng(raddr[p]) && m_pend[raddr[p]] && !(wr_en && wr_addr == raddr[p]);
        return req[p] && !blocked && !reset;
    endfunction

    task automatic model_step();
        bit g [2];
        bit oob;
        for (int p = 0; p < 2; p++) begin
            g[p]       = m_gnt(p);
            e_valid[p] = g[p];
            e_data[p]  = '0;
            e_hit[p]   = 1'b0;
            if (g[p] && !clr && in_rng(raddr[p])) begin
                if (wr_en && wr_addr == raddr[p]) begin
                    e_data[p] = wr_data;
                    e_hit[p]  = 1'b1;
                end else begin
                    e_data[p] = m_mem[raddr[p]];
                    e_hit[p]  = m_val[raddr[p]];
                end
            end
        end
        oob = (wr_en && !in_rng(wr_addr)) || (rsv_en && !in_rng(rsv_addr)) ||
              (g[0] && !in_rng(raddr[0])) || (g[1] && !in_rng(raddr[1]));
        if (reset || clr) begin
            for (int i = 0; i < TB_DEPTH; i++) begin
                m_mem[i]  = '0;
                m_val[i]  = 1'b0;
                m_pend[i] = 1'b0;
            end
            m_err = 1'b0;
        end else begin
            if (wr_en && in_rng(wr_addr)) begin
                m_mem[wr_addr]  = wr_data;
                m_val[wr_addr]  = 1'b1;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && in_rng(rsv_addr)) m_pend[rsv_addr] = 1'b1;
            if (oob) m_err = 1'b1;
        end
    endtask

    // Every-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("gnt%0d", p),   32'(gnt[p]),    32'(m_gnt(p)));
                chk($sformatf("valid%0d", p), 32'(rvalid[p]), 32'(e_valid[p]));
                chk($sformatf("data%0d", p),  32'(rdata[p]),  32'(e_data[p]));
                chk($sformatf("hit%0d", p),   32'(rhit[p]),   32'(e_hit[p]));
            end
            chk("err", 32'(err), 32'(m_err));
            model_step();
        end
    end

    task automatic idle();
        reset    = 1'b0;
        clr      = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        for (int p = 0; p < 2; p++) begin
            req[p]   = 1'b0;
            raddr[p] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        for (int i = 0; i < TB_DEPTH; i++) begin
            m_mem[i]  = '0;
            m_val[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
        for (int p = 0; p < 2; p++) begin
            e_valid[p] = 1'b0;
            e_data[p]  = '0;
            e_hit[p]   = 1'b0;
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // 1: read after reset
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd2;
        @(negedge clk); chk("t1 gnt", 32'(gnt[0]), 32'd1); chk("t1 err", 32'(err), 32'd0);
        next_cycle();
        @(negedge clk); chk("t1 valid", 32'(rvalid[0]), 32'd1);
        chk("t1 data", 32'(rdata[0]), 32'h0); chk("t1 hit", 32'(rhit[0]), 32'd0);

        // 2: write then dual-port read
        next_cycle(); wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd1; req[1] = 1'b1; raddr[1] = 3'd1;
        next_cycle();
        @(negedge clk);
        chk("t2 data a", 32'(rdata[0]), 32'hBEEF); chk("t2 hit a", 32'(rhit[0]), 32'd1);
        chk("t2 data b", 32'(rdata[1]), 32'hBEEF); chk("t2 valid b", 32'(rvalid[1]), 32'd1);

        // 3: reserve blocks reads until the producer writes (bypassed)
        next_cycle(); rsv_en = 1'b1; rsv_addr = 3'd3;
        for (int i = 0; i < 3; i++) begin
            next_cycle(); req[0] = 1'b1; raddr[0] = 3'd3;
            @(negedge clk); chk("t3 blocked gnt", 32'(gnt[0]), 32'd0);
            chk("t3 blocked valid", 32'(rvalid[0]), 32'd0);
        end
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd3;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        @(negedge clk); chk("t3 release gnt", 32'(gnt[0]), 32'd1);
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd3;
        @(negedge clk); chk("t3 bypass data", 32'(rdata[0]), 32'h1234);
        chk("t3 pend cleared gnt", 32'(gnt[0]), 32'd1);

        // 4: same-cycle write and reserve leaves the entry pending
        next_cycle(); wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hAAAA;
        rsv_en = 1'b1; rsv_addr = 3'd0;
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd0;
        @(negedge clk); chk("t4 pending gnt", 32'(gnt[0]), 32'd0);
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h5555;
        @(negedge clk); chk("t4 release gnt", 32'(gnt[0]), 32'd1);
        next_cycle();
        @(negedge clk); chk("t4 data", 32'(rdata[0]), 32'h5555);

        // 5: clear beats a same-cycle write and drops pending bits
        next_cycle(); rsv_en = 1'b1; rsv_addr = 3'd1;
        next_cycle(); clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h7777;
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd2; req[1] = 1'b1; raddr[1] = 3'd1;
        @(negedge clk); chk("t5 unpended gnt", 32'(gnt[1]), 32'd1);
        next_cycle();
        @(negedge clk); chk("t5 data", 32'(rdata[0]), 32'h0); chk("t5 hit", 32'(rhit[0]), 32'd0);

        // 6: out-of-range accesses and reset during a granted read
        next_cycle(); wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h9999;
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd6;
        @(negedge clk); chk("t6 err", 32'(err), 32'd1); chk("t6 oob gnt", 32'(gnt[0]), 32'd1);
        next_cycle();
        @(negedge clk); chk("t6 oob data", 32'(rdata[0]), 32'h0); chk("t6 oob hit", 32'(rhit[0]), 32'd0);
        next_cycle(); next_cycle();
        @(negedge clk); chk("t6 err sticky", 32'(err), 32'd1);
        next_cycle(); req[0] = 1'b1; raddr[0] = 3'd2; reset = 1'b1;
        next_cycle();
        @(negedge clk); chk("t6 reset valid", 32'(rvalid[0]), 32'd0); chk("t6 reset err", 32'(err), 32'd0);

        // Randomised traffic, checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            reset    = ($urandom_range(0, 99) == 0);
            clr      = ($urandom_range(0, 49) == 0);
            wr_en    = ($urandom_range(0, 9) < 4);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 16'($urandom);
            rsv_en   = ($urandom_range(0, 9) < 2);
            rsv_addr = 3'($urandom_range(0, 7));
            for (int p = 0; p < 2; p++) begin
                req[p]   = ($urandom_range(0, 9) < 7);
                raddr[p] = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) raddr[1] = raddr[0];
        end
        next_cycle();
        @(negedge clk);
        @(posedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
